// File: rtl/fp_pkg.sv
// Shared FP constants, FSM state encoding and operand classification helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int QUO_BITS = 26;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    DIVIDE = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4,
    DONE   = 3'd5
  } state_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
  endfunction

  // Denormals count as zero: the divider flushes them.
  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:23] == 8'h00);
  endfunction

endpackage

// File: rtl/fp_div_mantissa_core.sv
// Radix-2 restoring divider for 24-bit significands, one quotient bit per step.
// Latency: QUO_BITS step cycles after load; q/sticky stable once last has stepped.
// Backpressure: none; steps only when the controller asserts step.
module fp_div_mantissa_core
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [23:0] ma,
  input  logic [23:0] mb,
  output logic [25:0] q,
  output logic        sticky,
  output logic        last
);

  logic [25:0] rem_q;
  logic [23:0] div_q;
  logic [25:0] quo_q;
  logic [4:0]  cnt_q;

  logic [26:0] trial;
  logic        fits;
  logic [25:0] rem_sel;

  // Trial subtraction is done before the shift, so the first step yields the
  // integer quotient bit and the remainder stays below the divisor afterwards.
  always_comb begin
    trial   = {1'b0, rem_q} - {3'b000, div_q};
    fits    = ~trial[26];
    rem_sel = fits ? trial[25:0] : rem_q;
  end

  // Remainder, divisor, quotient and iteration counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= 26'h0;
      div_q <= 24'h0;
      quo_q <= 26'h0;
      cnt_q <= 5'd0;
    end else if (load) begin
      rem_q <= {2'b00, ma};
      div_q <= mb;
      quo_q <= 26'h0;
      cnt_q <= 5'd0;
    end else if (step) begin
      rem_q <= rem_sel << 1;
      quo_q <= {quo_q[24:0], fits};
      cnt_q <= last ? 5'd0 : cnt_q + 5'd1;
    end
  end

  assign q      = quo_q;
  assign sticky = (rem_q != 26'h0);
  assign last   = (cnt_q == 5'(QUO_BITS - 1));

endmodule

// File: rtl/fp_divider_single_seq.sv
// Sequential IEEE-754 single-precision divider, Div_Out = A / B (flush-to-zero, RNE).
// Latency: Done 30 clocks after an accepted Start, 2 clocks for special operands.
// Backpressure: Start is only accepted in IDLE or DONE; Start while Busy is dropped.
module fp_divider_single_seq
  import fp_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Div_Out,
  output logic        Busy,
  output logic        Done
);

  state_t state_q, state_d;

  logic [31:0]       a_q, b_q;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [25:0]       nq_q;
  logic              nsticky_q;

  logic              accept;
  logic              sign_unp;
  logic signed [9:0] exp_unp;
  logic              special;
  logic [31:0]       special_val;

  logic [25:0]       core_q;
  logic              core_sticky;
  logic              core_last;

  logic [23:0]       mant;
  logic              round_up;
  logic [24:0]       mant_r;
  logic signed [9:0] exp_r;
  logic [22:0]       frac_r;
  logic [31:0]       round_val;

  assign accept   = Start && ((state_q == IDLE) || (state_q == DONE));
  assign sign_unp = a_q[31] ^ b_q[31];
  assign exp_unp  = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
                  + 10'(EXP_BIAS);

  fp_div_mantissa_core u_core (
    .clk    (Clk),
    .rst    (Rst),
    .load   (state_q == UNPACK),
    .step   (state_q == DIVIDE),
    .ma     ({1'b1, a_q[22:0]}),
    .mb     ({1'b1, b_q[22:0]}),
    .q      (core_q),
    .sticky (core_sticky),
    .last   (core_last)
  );

  // Special operands bypass the divide loop; NaN-producing cases take priority.
  always_comb begin
    special     = 1'b0;
    special_val = 32'h0;
    if (is_nan(a_q) || is_nan(b_q) || (is_zero(a_q) && is_zero(b_q)) ||
        (is_inf(a_q) && is_inf(b_q))) begin
      special     = 1'b1;
      special_val = QNAN;
    end else if (is_inf(a_q) || is_zero(b_q)) begin
      special     = 1'b1;
      special_val = POS_INF | {sign_unp, 31'h0};
    end else if (is_zero(a_q) || is_inf(b_q)) begin
      special     = 1'b1;
      special_val = {sign_unp, 31'h0};
    end
  end

  // Round-to-nearest-even on the normalised quotient, then saturate the exponent.
  always_comb begin
    mant     = nq_q[25:2];
    round_up = nq_q[1] & (nq_q[0] | nsticky_q | mant[0]);
    mant_r   = {1'b0, mant} + {24'h0, round_up};
    exp_r    = exp_q + {9'h0, mant_r[24]};
    frac_r   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    if (exp_r >= 10'sd255) begin
      round_val = POS_INF | {sign_q, 31'h0};
    end else if (exp_r <= 10'sd0) begin
      round_val = {sign_q, 31'h0};
    end else begin
      round_val = {sign_q, exp_r[7:0], frac_r};
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and status outputs.
  always_comb begin
    state_d = state_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) state_d = UNPACK;
      end
      UNPACK: begin
        Busy    = 1'b1;
        state_d = special ? DONE : DIVIDE;
      end
      DIVIDE: begin
        Busy = 1'b1;
        if (core_last) state_d = NORM;
      end
      NORM: begin
        Busy    = 1'b1;
        state_d = ROUND;
      end
      ROUND: begin
        Busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        Done    = 1'b1;
        state_d = Start ? UNPACK : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, exponent/normalise bookkeeping and the held result.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      sign_q    <= 1'b0;
      exp_q     <= 10'sd0;
      nq_q      <= 26'h0;
      nsticky_q <= 1'b0;
      Div_Out   <= 32'h0;
    end else begin
      if (accept) begin
        a_q <= A;
        b_q <= B;
      end
      if (state_q == UNPACK) begin
        sign_q <= sign_unp;
        exp_q  <= exp_unp;
        if (special) Div_Out <= special_val;
      end
      if (state_q == NORM) begin
        nq_q      <= core_q[25] ? core_q : (core_q << 1);
        exp_q     <= core_q[25] ? exp_q : (exp_q - 10'sd1);
        nsticky_q <= core_sticky;
      end
      if (state_q == ROUND) Div_Out <= round_val;
    end
  end

endmodule
